// File: rtl/alu_multicycle_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_multicycle_pkg
//  Purpose  : Shared alucontrol op codes for the ALU decoder and execution
//             unit, plus a legality helper.
//  Revision : 1.0  initial release
// ============================================================================
package alu_multicycle_pkg;

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t ALU_AND = 4'b0000;
   localparam alu_op_t ALU_OR  = 4'b0001;
   localparam alu_op_t ALU_ADD = 4'b0010;
   localparam alu_op_t ALU_SUB = 4'b0110;
   localparam alu_op_t ALU_SLT = 4'b0111;
   localparam alu_op_t ALU_DIV = 4'b1010;

   // True for every code the execution unit implements.
   function automatic logic op_is_legal(input alu_op_t op);
      logic legal;
      legal = 1'b0;
      case (op)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_DIV: legal = 1'b1;
         default:                                            legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_multicycle_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_multicycle_if
//  Purpose  : Operand/result handshake bundle between register-read,
//             the ALU execution unit and writeback.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_multicycle_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alucontrol;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] remainder;
   logic             zero;
   logic             div_by_zero;
   logic             illegal_op;

   // Datapath side: presents operations, consumes results.
   modport master (
      output in_valid, alucontrol, src_a, src_b, out_ready,
      input  in_ready, out_valid, result, remainder, zero, div_by_zero, illegal_op
   );

   // ALU side.
   modport slave (
      input  in_valid, alucontrol, src_a, src_b, out_ready,
      output in_ready, out_valid, result, remainder, zero, div_by_zero, illegal_op
   );
endinterface
`default_nettype wire

// File: rtl/alu_div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_div_iter
//  Purpose  : Radix-2 restoring divider on unsigned magnitudes. The first
//             shift/subtract step is folded into the start cycle so that
//             the iteration count reaches WIDTH one cycle before the owner
//             captures the result.
//  Revision : 1.0  initial release
// ============================================================================
module alu_div_iter #(
   parameter int WIDTH = 32
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   input  wire logic             start,
   input  wire logic [WIDTH-1:0] dividend,
   input  wire logic [WIDTH-1:0] divisor,
   output logic                  done,
   output logic [WIDTH-1:0]      quotient,
   output logic [WIDTH-1:0]      remainder
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvs;
   logic [CNT_W-1:0] count;
   logic             running;

   // One restoring step: shift the next dividend bit into the partial
   // remainder and subtract the divisor when it fits. Returns {rem, quo}.
   function automatic logic [2*WIDTH-1:0] div_step(
      input logic [WIDTH-1:0] r,
      input logic [WIDTH-1:0] q,
      input logic [WIDTH-1:0] d
   );
      logic [WIDTH:0] trial;
      logic [WIDTH:0] diff;
      trial = {r, q[WIDTH-1]};
      diff  = trial - {1'b0, d};
      // diff[WIDTH] set means trial < divisor: restore.
      if (diff[WIDTH])
         return {trial[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
      else
         return {diff[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
   endfunction

   // Iteration registers: load with first step on start, then step until done.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         quo     <= '0;
         rem     <= '0;
         dvs     <= '0;
         count   <= '0;
         running <= 1'b0;
      end else if (start) begin
         {rem, quo} <= div_step('0, dividend, divisor);
         dvs        <= divisor;
         count      <= CNT_W'(1);
         running    <= 1'b1;
      end else if (running && (count != LAST)) begin
         {rem, quo} <= div_step(rem, quo, dvs);
         count      <= count + CNT_W'(1);
      end else if (done) begin
         running <= 1'b0;
      end
   end

   assign done      = running && (count == LAST);
   assign quotient  = quo;
   assign remainder = rem;

endmodule
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module   : alu_multicycle
//  Purpose  : ALU execution unit. AND/OR/ADD/SUB/SLT complete in one cycle,
//             DIV iterates WIDTH steps. valid/ready on both sides.
//  Config   : ALU_SIGNED_DIV_EN - signed (truncating) DIV; unsigned if not
//             defined.
//  Revision : 1.0  initial release
// ============================================================================
module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input wire logic         clk,
   input wire logic         reset_n,
   alu_multicycle_if.slave  bus
);
   import alu_multicycle_pkg::*;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             div_start;
   logic             in_ready;
   logic             out_valid;
   logic             legal;
   logic             b_zero;
   logic             div_done;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] div_q;
   logic [WIDTH-1:0] div_r;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic [WIDTH-1:0] sc_result;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] remainder_q;
   logic             dbz_q;
   logic             illegal_q;

   assign legal  = op_is_legal(bus.alucontrol);
   assign b_zero = (bus.src_b == '0);

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next state and handshake outputs; DIV by a non-zero divisor is the
   // only path through BUSY.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      div_start = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               accept = 1'b1;
               if ((bus.alucontrol == ALU_DIV) && !b_zero) begin
                  div_start = 1'b1;
                  state_nxt = BUSY;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         BUSY: begin
            if (div_done) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Single-cycle operations, evaluated on the operands being accepted.
   always_comb begin
      sc_result = '0;
      case (bus.alucontrol)
         ALU_AND: sc_result = bus.src_a & bus.src_b;
         ALU_OR:  sc_result = bus.src_a | bus.src_b;
         ALU_ADD: sc_result = bus.src_a + bus.src_b;
         ALU_SUB: sc_result = bus.src_a - bus.src_b;
         ALU_SLT: sc_result = {{(WIDTH-1){1'b0}},
                               ($signed(bus.src_a) < $signed(bus.src_b))};
         default: sc_result = '0;
      endcase
   end

`ifdef ALU_SIGNED_DIV_EN
   logic q_neg;
   logic r_neg;

   // Signs of the accepted DIV operands, applied when the result is captured.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else if (div_start) begin
         q_neg <= bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1];
         r_neg <= bus.src_a[WIDTH-1];
      end
   end

   // MIN has no positive counterpart; its magnitude as unsigned is still
   // exact, and MIN / -1 then naturally yields quotient MIN, remainder 0.
   assign a_mag = bus.src_a[WIDTH-1] ? -bus.src_a : bus.src_a;
   assign b_mag = bus.src_b[WIDTH-1] ? -bus.src_b : bus.src_b;
   assign q_fix = q_neg ? -div_q : div_q;
   assign r_fix = r_neg ? -div_r : div_r;
`else
   assign a_mag = bus.src_a;
   assign b_mag = bus.src_b;
   assign q_fix = div_q;
   assign r_fix = div_r;
`endif

   alu_div_iter #(
      .WIDTH (WIDTH)
   ) u_div (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (div_start),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .done      (div_done),
      .quotient  (div_q),
      .remainder (div_r)
   );

   // Result registers: loaded at accept for immediate ops, at divider
   // completion for iterative DIV, otherwise held.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         result_q    <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         illegal_q   <= 1'b0;
      end else if (accept) begin
         dbz_q     <= 1'b0;
         illegal_q <= 1'b0;
         if (!legal) begin
            result_q    <= '0;
            remainder_q <= '0;
            illegal_q   <= 1'b1;
         end else if (bus.alucontrol == ALU_DIV) begin
            if (b_zero) begin
               result_q    <= '1;
               remainder_q <= bus.src_a;
               dbz_q       <= 1'b1;
            end
         end else begin
            result_q    <= sc_result;
            remainder_q <= '0;
         end
      end else if ((state == BUSY) && div_done) begin
         result_q    <= q_fix;
         remainder_q <= r_fix;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid;
   assign bus.result      = result_q;
   assign bus.remainder   = remainder_q;
   assign bus.zero        = out_valid && (result_q == '0);
   assign bus.div_by_zero = dbz_q;
   assign bus.illegal_op  = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_multicycle
//  Purpose  : Self-checking bench for alu_multicycle with a result queue.
//  Config   : ALU_SIGNED_DIV_EN selects signed DIV expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_multicycle;

   localparam int WIDTH = 32;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic [WIDTH-1:0] rem;
      logic             zero;
      logic             dbz;
      logic             ill;
      int               lat;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];

   alu_multicycle_if #(.WIDTH(WIDTH)) bus ();

   alu_multicycle #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference behaviour of one operation.
   function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b);
      exp_t e;
      e.res = '0; e.rem = '0; e.dbz = 1'b0; e.ill = 1'b0; e.lat = 1;
      case (op)
         4'b0000: e.res = a & b;
         4'b0001: e.res = a | b;
         4'b0010: e.res = a + b;
         4'b0110: e.res = a - b;
         4'b0111: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
         4'b1010: begin
            if (b == 0) begin
               e.res = '1; e.rem = a; e.dbz = 1'b1;
            end else begin
               e.lat = WIDTH + 1;
`ifdef ALU_SIGNED_DIV_EN
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                  e.res = a; e.rem = '0;
               end else begin
                  e.res = $signed(a) / $signed(b);
                  e.rem = $signed(a) % $signed(b);
               end
`else
               e.res = a / b;
               e.rem = a % b;
`endif
            end
         end
         default: e.ill = 1'b1;
      endcase
      e.zero = (e.res == 0);
      return e;
   endfunction

   // Drive one op, wait for its result, compare against the queue head,
   // optionally stall the consumer, then complete the handshake.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input int hold);
      exp_t e;
      int   lat;
      bit   rdy_bad;
      bit   unstable;
      logic [WIDTH-1:0] r0, m0;
      @(negedge clk);
      check_eq({tag, ":in_ready"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid   = 1'b1;
      bus.alucontrol = op;
      bus.src_a      = a;
      bus.src_b      = b;
      exp_q.push_back(model(op, a, b));
      @(negedge clk);
      // Garbage while the op is in flight must not be picked up.
      bus.alucontrol = 4'($urandom);
      bus.src_a      = $urandom;
      bus.src_b      = $urandom;
      lat     = 1;
      rdy_bad = 1'b0;
      while (!bus.out_valid && lat < 100) begin
         if (bus.in_ready) rdy_bad = 1'b1;
         @(negedge clk);
         lat++;
      end
      bus.in_valid = 1'b0;
      if (bus.in_ready) rdy_bad = 1'b1;
      if (exp_q.size() == 0) begin
         check_eq({tag, ":queue_empty"}, 64'd1, 64'd0);
         return;
      end
      e = exp_q.pop_front();
      if (!bus.out_valid) begin
         check_eq({tag, ":timeout"}, 64'(bus.out_valid), 64'd1);
         return;
      end
      check_eq({tag, ":latency"},   64'(lat),             64'(e.lat));
      check_eq({tag, ":result"},    64'(bus.result),      64'(e.res));
      check_eq({tag, ":remainder"}, 64'(bus.remainder),   64'(e.rem));
      check_eq({tag, ":zero"},      64'(bus.zero),        64'(e.zero));
      check_eq({tag, ":dbz"},       64'(bus.div_by_zero), 64'(e.dbz));
      check_eq({tag, ":illegal"},   64'(bus.illegal_op),  64'(e.ill));
      check_eq({tag, ":ready_low"}, 64'(rdy_bad),         64'd0);
      if (hold > 0) begin
         r0 = bus.result;
         m0 = bus.remainder;
         unstable = 1'b0;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.result !== r0 || bus.remainder !== m0 || bus.in_ready)
               unstable = 1'b1;
         end
         check_eq({tag, ":hold_stable"}, 64'(unstable), 64'd0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_eq({tag, ":valid_drop"}, 64'(bus.out_valid), 64'd0);
      check_eq({tag, ":ready_back"}, 64'(bus.in_ready),  64'd1);
   endtask

   initial begin
      logic [3:0] ops [7];
      bit stale;
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1010, 4'b1111};
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.alucontrol = '0; bus.src_a = '0; bus.src_b = '0;
      repeat (3) @(negedge clk);
      check_eq("rst:out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst:in_ready",  64'(bus.in_ready),  64'd1);
      check_eq("rst:result",    64'(bus.result),    64'd0);
      check_eq("rst:zero",      64'(bus.zero),      64'd0);
      reset_n = 1'b1;

      run_op("add",   4'b0010, 32'd7,      32'd5,      0);
      run_op("sub",   4'b0110, 32'd5,      32'd7,      0);
      run_op("and",   4'b0000, 32'hF0F0,   32'h0FF0,   0);
      run_op("or",    4'b0001, 32'hF0F0,   32'h0FF0,   0);
      run_op("slt_n", 4'b0111, 32'hFFFF_FFFF, 32'd1,   0);
      run_op("slt_eq",4'b0111, 32'd3,      32'd3,      0);
      run_op("div",   4'b1010, 32'd100,    32'd7,      0);
      run_op("div0",  4'b1010, 32'd9,      32'd0,      0);
      run_op("ill",   4'b1111, 32'd1,      32'd2,      0);
      run_op("bp",    4'b0010, 32'd1,      32'd2,      5);
      run_op("bp_div",4'b1010, 32'hFFFF_FFFF, 32'd1,   3);
      run_op("div_sm",4'b1010, 32'd5,      32'd10,     0);
      run_op("div_bg",4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
`ifdef ALU_SIGNED_DIV_EN
      run_op("sdiv",  4'b1010, 32'hFFFF_FFF9, 32'd2,   0);
`endif

      for (int i = 0; i < 20; i++) begin
         logic [3:0] op;
         logic [WIDTH-1:0] b;
         op = ops[$urandom_range(0, 6)];
         b  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : $urandom;
         run_op("rand", op, $urandom, b, $urandom_range(0, 2));
      end

      // Reset in the middle of a DIV: no result may appear afterwards.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.alucontrol = 4'b1010;
      bus.src_a = 32'd100; bus.src_b = 32'd7;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("mid_rst:out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("mid_rst:in_ready",  64'(bus.in_ready),  64'd1);
      check_eq("mid_rst:result",    64'(bus.result),    64'd0);
      reset_n = 1'b1;
      stale = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid || !bus.in_ready) stale = 1'b1;
      end
      check_eq("mid_rst:no_stale", 64'(stale), 64'd0);
      run_op("post_rst", 4'b0010, 32'd40, 32'd2, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
